assoc_array_access_ctrl: RTL and testbench

ASSOC_ARRAY_ACCESS_CTRL -- requirements
Module: assoc_array_access_ctrl

---
 rtl/assoc_array_access_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_assoc_array_access_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_array_access_ctrl.sv
// Access controller for a set-associative tag array.
// Lookups and fills share one read/compare sequence; fills then write the chosen victim way.
module assoc_array_access_ctrl #(
    parameter int unsigned NUM_SET               = 64,
    parameter int unsigned NUM_WAY               = 16,
    parameter int unsigned TAG_WIDTH             = 63,
    parameter int unsigned SET_PTR_WIDTH_IN_BITS = $clog2(NUM_SET)
) (
    input  logic                               clk_in,
    input  logic                               reset_in,
    input  logic                               lookup_valid_in,
    output logic                               lookup_ready_out,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]   lookup_set_in,
    input  logic [TAG_WIDTH-1:0]               lookup_tag_in,
    output logic                               resp_valid_out,
    input  logic                               resp_ready_in,
    output logic                               resp_hit_out,
    output logic [NUM_WAY-1:0]                 resp_way_out,
    input  logic                               fill_valid_in,
    output logic                               fill_ready_out,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]   fill_set_in,
    input  logic [TAG_WIDTH-1:0]               fill_tag_in,
    output logic                               fill_done_out,
    output logic [NUM_WAY-1:0]                 fill_way_out,
    output logic                               array_access_en_out,
    output logic                               array_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]   array_set_addr_out,
    output logic [NUM_WAY-1:0]                 array_way_select_out,
    output logic [TAG_WIDTH:0]                 array_write_entry_out,
    input  logic [(TAG_WIDTH+1)*NUM_WAY-1:0]   array_read_set_in
);

    localparam int unsigned ENTRY_W = TAG_WIDTH + 1;
    localparam int unsigned RR_W    = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CMP  = 3'd2,
        RESP = 3'd3,
        WR   = 3'd4
    } state_t;

    state_t                           state_q,      state_d;
    logic                             op_fill_q,    op_fill_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] set_q,        set_d;
    logic [TAG_WIDTH-1:0]             tag_q,        tag_d;
    logic [RR_W-1:0]                  rr_ptr_q,     rr_ptr_d;
    logic                             resp_valid_q, resp_valid_d;
    logic                             resp_hit_q,   resp_hit_d;
    logic [NUM_WAY-1:0]               resp_way_q,   resp_way_d;
    logic                             fill_done_q,  fill_done_d;
    logic [NUM_WAY-1:0]               fill_way_q,   fill_way_d;
    logic                             acc_en_q,     acc_en_d;
    logic                             wr_en_q,      wr_en_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] set_addr_q,   set_addr_d;
    logic [NUM_WAY-1:0]               way_sel_q,    way_sel_d;
    logic [ENTRY_W-1:0]               wr_entry_q,   wr_entry_d;

    logic [ENTRY_W-1:0] entry;
    logic [NUM_WAY-1:0] hit_vec;
    logic [NUM_WAY-1:0] inv_vec;
    logic [NUM_WAY-1:0] hit_oh;
    logic [NUM_WAY-1:0] inv_oh;
    logic [NUM_WAY-1:0] rr_oh;
    logic [NUM_WAY-1:0] victim_oh;
    logic               victim_from_rr;

    // Ready only in IDLE; a pending fill blocks lookups.
    assign fill_ready_out   = (state_q == IDLE) && !reset_in;
    assign lookup_ready_out = (state_q == IDLE) && !reset_in && !fill_valid_in;

    assign resp_valid_out        = resp_valid_q;
    assign resp_hit_out          = resp_hit_q;
    assign resp_way_out          = resp_way_q;
    assign fill_done_out         = fill_done_q;
    assign fill_way_out          = fill_way_q;
    assign array_access_en_out   = acc_en_q;
    assign array_write_en_out    = wr_en_q;
    assign array_set_addr_out    = set_addr_q;
    assign array_way_select_out  = way_sel_q;
    assign array_write_entry_out = wr_entry_q;

    // Per-way tag match and victim selection on the set read back from the array.
    always_comb begin
        entry          = '0;
        hit_vec        = '0;
        inv_vec        = '0;
        for (int unsigned g = 0; g < NUM_WAY; g++) begin
            entry      = array_read_set_in[g*ENTRY_W +: ENTRY_W];
            hit_vec[g] = entry[ENTRY_W-1] && (entry[TAG_WIDTH-1:0] == tag_q);
            inv_vec[g] = !entry[ENTRY_W-1];
        end
        hit_oh         = hit_vec & (~hit_vec + NUM_WAY'(1));
        inv_oh         = inv_vec & (~inv_vec + NUM_WAY'(1));
        rr_oh          = NUM_WAY'(1) << rr_ptr_q;
        victim_from_rr = 1'b0;
        if (|hit_vec) begin
            victim_oh = hit_oh;
        end else if (|inv_vec) begin
            victim_oh = inv_oh;
        end else begin
            victim_oh      = rr_oh;
            victim_from_rr = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        op_fill_d    = op_fill_q;
        set_d        = set_q;
        tag_d        = tag_q;
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        resp_way_d   = resp_way_q;
        fill_done_d  = 1'b0;
        fill_way_d   = fill_way_q;
        acc_en_d     = 1'b0;
        wr_en_d      = 1'b0;
        set_addr_d   = set_addr_q;
        way_sel_d    = '0;
        wr_entry_d   = wr_entry_q;

        case (state_q)
            IDLE: begin
                if (fill_valid_in) begin
                    op_fill_d  = 1'b1;
                    set_d      = fill_set_in;
                    tag_d      = fill_tag_in;
                    set_addr_d = fill_set_in;
                    acc_en_d   = 1'b1;
                    way_sel_d  = '1;
                    state_d    = RD;
                end else if (lookup_valid_in) begin
                    op_fill_d  = 1'b0;
                    set_d      = lookup_set_in;
                    tag_d      = lookup_tag_in;
                    set_addr_d = lookup_set_in;
                    acc_en_d   = 1'b1;
                    way_sel_d  = '1;
                    state_d    = RD;
                end
            end
            RD: begin
                state_d = CMP;
            end
            CMP: begin
                if (op_fill_q) begin
                    if (victim_from_rr) begin
                        if (rr_ptr_q == RR_W'(NUM_WAY - 1)) begin
                            rr_ptr_d = '0;
                        end else begin
                            rr_ptr_d = rr_ptr_q + RR_W'(1);
                        end
                    end
                    acc_en_d   = 1'b1;
                    wr_en_d    = 1'b1;
                    set_addr_d = set_q;
                    way_sel_d  = victim_oh;
                    wr_entry_d = {1'b1, tag_q};
                    state_d    = WR;
                end else begin
                    resp_hit_d   = |hit_vec;
                    resp_way_d   = hit_oh;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready_in) begin
                    state_d = IDLE;
                end else begin
                    resp_valid_d = 1'b1;
                end
            end
            WR: begin
                fill_done_d = 1'b1;
                fill_way_d  = way_sel_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any request in flight.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= IDLE;
            op_fill_q    <= 1'b0;
            set_q        <= '0;
            tag_q        <= '0;
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            fill_done_q  <= 1'b0;
            fill_way_q   <= '0;
            acc_en_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            set_addr_q   <= '0;
            way_sel_q    <= '0;
            wr_entry_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_fill_q    <= op_fill_d;
            set_q        <= set_d;
            tag_q        <= tag_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_way_q   <= resp_way_d;
            fill_done_q  <= fill_done_d;
            fill_way_q   <= fill_way_d;
            acc_en_q     <= acc_en_d;
            wr_en_q      <= wr_en_d;
            set_addr_q   <= set_addr_d;
            way_sel_q    <= way_sel_d;
            wr_entry_q   <= wr_entry_d;
        end
    end

endmodule

// File: tb/tb_assoc_array_access_ctrl.sv
// Bench for assoc_array_access_ctrl: array memory, transaction-level model, per-cycle compare.
module tb_assoc_array_access_ctrl;

    localparam int NS = 64;
    localparam int NW = 16;
    localparam int TW = 63;
    localparam int SW = 6;
    localparam int EW = TW + 1;

    logic            clk_in          = 1'b0;
    logic            reset_in        = 1'b1;
    logic            lookup_valid_in = 1'b0;
    logic            lookup_ready_out;
    logic [SW-1:0]   lookup_set_in   = '0;
    logic [TW-1:0]   lookup_tag_in   = '0;
    logic            resp_valid_out;
    logic            resp_ready_in   = 1'b1;
    logic            resp_hit_out;
    logic [NW-1:0]   resp_way_out;
    logic            fill_valid_in   = 1'b0;
    logic            fill_ready_out;
    logic [SW-1:0]   fill_set_in     = '0;
    logic [TW-1:0]   fill_tag_in     = '0;
    logic            fill_done_out;
    logic [NW-1:0]   fill_way_out;
    logic            array_access_en_out;
    logic            array_write_en_out;
    logic [SW-1:0]   array_set_addr_out;
    logic [NW-1:0]   array_way_select_out;
    logic [EW-1:0]   array_write_entry_out;
    logic [EW*NW-1:0] array_read_set_in;

    int n_cmp = 0;
    int n_err = 0;

    assoc_array_access_ctrl dut (
        .clk_in                (clk_in),
        .reset_in              (reset_in),
        .lookup_valid_in       (lookup_valid_in),
        .lookup_ready_out      (lookup_ready_out),
        .lookup_set_in         (lookup_set_in),
        .lookup_tag_in         (lookup_tag_in),
        .resp_valid_out        (resp_valid_out),
        .resp_ready_in         (resp_ready_in),
        .resp_hit_out          (resp_hit_out),
        .resp_way_out          (resp_way_out),
        .fill_valid_in         (fill_valid_in),
        .fill_ready_out        (fill_ready_out),
        .fill_set_in           (fill_set_in),
        .fill_tag_in           (fill_tag_in),
        .fill_done_out         (fill_done_out),
        .fill_way_out          (fill_way_out),
        .array_access_en_out   (array_access_en_out),
        .array_write_en_out    (array_write_en_out),
        .array_set_addr_out    (array_set_addr_out),
        .array_way_select_out  (array_way_select_out),
        .array_write_entry_out (array_write_entry_out),
        .array_read_set_in     (array_read_set_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous-read tag array the controller drives.
    logic [EW-1:0]    mem [NS][NW] = '{default: '0};
    logic [EW*NW-1:0] rd_q = '0;
    assign array_read_set_in = rd_q;

    always @(posedge clk_in) begin
        if (array_access_en_out && array_write_en_out) begin
            for (int w = 0; w < NW; w++)
                if (array_way_select_out[w]) mem[array_set_addr_out][w] <= array_write_entry_out;
        end else if (array_access_en_out) begin
            for (int w = 0; w < NW; w++)
                rd_q[w*EW +: EW] <= mem[array_set_addr_out][w];
        end
    end

    // Model: expected array contents plus a cycle count since acceptance.
    logic [EW-1:0] shadow [NS][NW] = '{default: '0};
    bit            m_busy     = 1'b0;
    bit            m_fill     = 1'b0;
    bit            m_done     = 1'b0;
    bit            m_resp_hit = 1'b0;
    int            m_k        = 0;
    int            rr         = 0;
    int            mh         = 0;
    int            mv         = 0;
    logic [SW-1:0] m_set      = '0;
    logic [TW-1:0] m_tag      = '0;
    logic [NW-1:0] m_victim   = '0;
    logic [NW-1:0] m_fill_way = '0;
    logic [NW-1:0] m_resp_way = '0;

    function automatic int find_hit(input logic [SW-1:0] s, input logic [TW-1:0] t);
        for (int w = 0; w < NW; w++)
            if (shadow[s][w][EW-1] && shadow[s][w][TW-1:0] == t) return w;
        return -1;
    endfunction

    function automatic int find_invalid(input logic [SW-1:0] s);
        for (int w = 0; w < NW; w++)
            if (!shadow[s][w][EW-1]) return w;
        return -1;
    endfunction

    always @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            m_busy     = 1'b0;
            m_k        = 0;
            m_done     = 1'b0;
            rr         = 0;
            m_fill_way = '0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (fill_valid_in) begin
                    m_busy = 1'b1; m_k = 1; m_fill = 1'b1;
                    m_set  = fill_set_in; m_tag = fill_tag_in;
                    mh = find_hit(m_set, m_tag);
                    if (mh >= 0) mv = mh;
                    else begin
                        mv = find_invalid(m_set);
                        if (mv < 0) begin
                            mv = rr;
                            rr = (rr + 1) % NW;
                        end
                    end
                    m_victim = NW'(1) << mv;
                end else if (lookup_valid_in) begin
                    m_busy = 1'b1; m_k = 1; m_fill = 1'b0;
                    m_set  = lookup_set_in; m_tag = lookup_tag_in;
                    mh = find_hit(m_set, m_tag);
                    m_resp_hit = (mh >= 0);
                    m_resp_way = (mh >= 0) ? (NW'(1) << mh) : '0;
                end
            end else if (m_fill && m_k == 3) begin
                shadow[m_set][mv] = {1'b1, m_tag};
                m_done     = 1'b1;
                m_fill_way = m_victim;
                m_busy     = 1'b0;
            end else if (!m_fill && m_k >= 3 && resp_ready_in) begin
                m_busy = 1'b0;
            end else begin
                m_k++;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_in) begin
        if (reset_in) begin
            chk("rst_lookup_ready", lookup_ready_out, 0);
            chk("rst_fill_ready", fill_ready_out, 0);
            chk("rst_resp_valid", resp_valid_out, 0);
            chk("rst_resp_hit", resp_hit_out, 0);
            chk("rst_resp_way", resp_way_out, 0);
            chk("rst_fill_done", fill_done_out, 0);
            chk("rst_fill_way", fill_way_out, 0);
            chk("rst_acc_en", array_access_en_out, 0);
            chk("rst_wr_en", array_write_en_out, 0);
            chk("rst_set_addr", array_set_addr_out, 0);
            chk("rst_way_sel", array_way_select_out, 0);
            chk("rst_wr_entry", array_write_entry_out, 0);
        end else begin
            automatic bit rdp = m_busy && m_k == 1;
            automatic bit wrp = m_busy && m_fill && m_k == 3;
            automatic bit rsp = m_busy && !m_fill && m_k >= 3;
            chk("fill_ready", fill_ready_out, !m_busy);
            chk("lookup_ready", lookup_ready_out, !m_busy && !fill_valid_in);
            chk("acc_en", array_access_en_out, rdp || wrp);
            chk("wr_en", array_write_en_out, wrp);
            chk("way_sel", array_way_select_out, rdp ? {NW{1'b1}} : (wrp ? m_victim : '0));
            if (rdp || wrp) chk("set_addr", array_set_addr_out, m_set);
            if (wrp) chk("wr_entry", array_write_entry_out, {1'b1, m_tag});
            chk("resp_valid", resp_valid_out, rsp);
            if (rsp) begin
                chk("resp_hit", resp_hit_out, m_resp_hit);
                chk("resp_way", resp_way_out, m_resp_way);
            end
            chk("fill_done", fill_done_out, m_done);
            chk("fill_way", fill_way_out, m_fill_way);
        end
    end

    task automatic send_fill(input logic [SW-1:0] s, input logic [TW-1:0] t);
        int n;
        fill_set_in = s; fill_tag_in = t; fill_valid_in = 1'b1;
        n = 0;
        do begin @(negedge clk_in); n++; end while (!fill_ready_out && n < 50);
        chk("fill_accept", fill_ready_out, 1);
        @(posedge clk_in); #1;
        fill_valid_in = 1'b0;
    endtask

    task automatic do_fill(input logic [SW-1:0] s, input logic [TW-1:0] t,
                           input logic [NW-1:0] exp_way, input string name);
        int n;
        send_fill(s, t);
        n = 0;
        do begin @(negedge clk_in); n++; end while (!fill_done_out && n < 20);
        chk({name, "_lat"}, n, 4);
        chk({name, "_way"}, fill_way_out, exp_way);
        @(posedge clk_in); #1;
    endtask

    task automatic send_lookup(input logic [SW-1:0] s, input logic [TW-1:0] t,
                               output logic hit, output logic [NW-1:0] way, output int lat);
        int n;
        lookup_set_in = s; lookup_tag_in = t; lookup_valid_in = 1'b1;
        n = 0;
        do begin @(negedge clk_in); n++; end while (!lookup_ready_out && n < 50);
        chk("lookup_accept", lookup_ready_out, 1);
        @(posedge clk_in); #1;
        lookup_valid_in = 1'b0;
        n = 0;
        do begin @(negedge clk_in); n++; end while (!resp_valid_out && n < 20);
        lat = n; hit = resp_hit_out; way = resp_way_out;
    endtask

    task automatic do_lookup(input logic [SW-1:0] s, input logic [TW-1:0] t,
                             input logic exp_hit, input logic [NW-1:0] exp_way, input string name);
        logic hit; logic [NW-1:0] way; int lat;
        send_lookup(s, t, hit, way, lat);
        chk({name, "_lat"}, lat, 3);
        chk({name, "_hit"}, hit, exp_hit);
        chk({name, "_way"}, way, exp_way);
        @(posedge clk_in); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hit; logic [NW-1:0] way; int lat; int n;
        logic [NW-1:0] ew;

        repeat (3) @(negedge clk_in);
        chk("init_resp_valid", resp_valid_out, 0);
        chk("init_fill_ready", fill_ready_out, 0);
        @(posedge clk_in); #1;
        reset_in = 1'b0;
        @(negedge clk_in);
        chk("post_rst_fill_ready", fill_ready_out, 1);
        chk("post_rst_lookup_ready", lookup_ready_out, 1);
        @(posedge clk_in); #1;

        // Fill into an empty set lands in way 0.
        do_fill(6'd5, 63'hA, 16'h0001, "fill_s5_a");
        chk("arr_s5_w0", mem[5][0], 64'h8000_0000_0000_000A);
        do_lookup(6'd5, 63'hA, 1'b1, 16'h0001, "lk_s5_a");
        do_lookup(6'd5, 63'hB, 1'b0, 16'h0000, "lk_s5_b");

        // Eighteen distinct tags into set 3: invalid ways first, then round-robin wraps.
        for (int i = 0; i < NW + 2; i++) begin
            ew = (i < NW) ? (NW'(1) << i) : (NW'(1) << (i - NW));
            do_fill(6'd3, 63'h100 + 63'(i), ew, "fill_s3");
        end
        // Tag already in way 7 rewrites it without moving the pointer, which stays at 2.
        do_fill(6'd3, 63'h107, 16'h0080, "fill_s3_dup");
        do_fill(6'd3, 63'h200, 16'h0004, "fill_s3_rr2");
        do_lookup(6'd3, 63'h110, 1'b1, 16'h0001, "lk_s3_wrap");
        do_lookup(6'd3, 63'h100, 1'b0, 16'h0000, "lk_s3_evicted");

        // Simultaneous fill and lookup: fill wins, the lookup then hits the new line.
        fill_set_in = 6'd9; fill_tag_in = 63'h77; fill_valid_in = 1'b1;
        lookup_set_in = 6'd9; lookup_tag_in = 63'h77; lookup_valid_in = 1'b1;
        @(negedge clk_in);
        chk("both_fill_ready", fill_ready_out, 1);
        chk("both_lookup_ready", lookup_ready_out, 0);
        @(posedge clk_in); #1;
        fill_valid_in = 1'b0;
        n = 0;
        do begin @(negedge clk_in); n++; end while (!fill_done_out && n < 20);
        chk("both_fill_lat", n, 4);
        chk("both_fill_way", fill_way_out, 16'h0001);
        chk("both_lookup_ready_after", lookup_ready_out, 1);
        @(posedge clk_in); #1;
        lookup_valid_in = 1'b0;
        n = 0;
        do begin @(negedge clk_in); n++; end while (!resp_valid_out && n < 20);
        chk("both_lk_lat", n, 3);
        chk("both_lk_hit", resp_hit_out, 1);
        chk("both_lk_way", resp_way_out, 16'h0001);
        @(posedge clk_in); #1;

        // Response back-pressure: data held, no new requests accepted.
        resp_ready_in = 1'b0;
        send_lookup(6'd5, 63'hA, hit, way, lat);
        chk("hold_lat", lat, 3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_in);
            chk("hold_valid", resp_valid_out, 1);
            chk("hold_hit", resp_hit_out, 1);
            chk("hold_way", resp_way_out, 16'h0001);
            chk("hold_lookup_ready", lookup_ready_out, 0);
            chk("hold_fill_ready", fill_ready_out, 0);
        end
        resp_ready_in = 1'b1;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("hold_release_valid", resp_valid_out, 0);
        @(posedge clk_in); #1;

        // Reset while the fill is in RD: no write, no pulse, back to IDLE.
        send_fill(6'd6, 63'h55);
        reset_in = 1'b1;
        @(negedge clk_in);
        @(posedge clk_in); #1;
        reset_in = 1'b0;
        repeat (6) @(negedge clk_in);
        chk("rst_mid_no_write", mem[6][0][EW-1], 0);
        chk("rst_mid_idle", fill_ready_out, 1);
        @(posedge clk_in); #1;
        do_lookup(6'd6, 63'h55, 1'b0, 16'h0000, "lk_s6_after_rst");

        repeat (2) @(negedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
